// File: rtl/exibe_sequencia_ctrl_if.sv
// Handshake and datapath signals between the game control unit, the sequence
// memory/LEDs and the playback controller. EXIBE_SEQUENCIA_RGB_EN adds the rgb output.
interface exibe_sequencia_ctrl_if;
   logic       iniciar;
   logic       abortar;
   logic [3:0] limite;
   logic [3:0] dado_memoria;
   logic [3:0] endereco;
   logic [3:0] leds;
   logic       ocupado;
   logic       pronto;
   logic [3:0] db_estado;
`ifdef EXIBE_SEQUENCIA_RGB_EN
   logic [2:0] rgb;

   modport master (output iniciar, abortar, limite, dado_memoria,
                   input  endereco, leds, ocupado, pronto, db_estado, rgb);
   modport slave  (input  iniciar, abortar, limite, dado_memoria,
                   output endereco, leds, ocupado, pronto, db_estado, rgb);
`else
   modport master (output iniciar, abortar, limite, dado_memoria,
                   input  endereco, leds, ocupado, pronto, db_estado);
   modport slave  (input  iniciar, abortar, limite, dado_memoria,
                   output endereco, leds, ocupado, pronto, db_estado);
`endif
endinterface

// File: rtl/exibe_sequencia_ctrl.sv
// Plays the stored colour sequence (addresses 0..limite) on the LEDs before each round.
// EXIBE_SEQUENCIA_RGB_EN adds a one-hot-to-RGB decode of the LED value.
//
// state   | meaning
// INICIAL | idle, waiting for iniciar
// PREPARA | clear address and timer
// ACENDE  | show dado_memoria for T_ACESO cycles
// APAGA   | blank gap for T_APAGADO cycles
// PROXIMO | advance address
// FIM     | one-cycle pronto pulse
module exibe_sequencia_ctrl #(
   parameter int T_ACESO   = 1000,
   parameter int T_APAGADO = 500
) (
   input  logic                    clock,
   input  logic                    reset,
   exibe_sequencia_ctrl_if.slave   bus
);
   localparam int T_MAX = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
   localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   localparam logic [TW-1:0] FIM_ACESO   = TW'(T_ACESO - 1);
   localparam logic [TW-1:0] FIM_APAGADO = TW'(T_APAGADO - 1);

   localparam logic [2:0] INICIAL = 3'd0;
   localparam logic [2:0] PREPARA = 3'd1;
   localparam logic [2:0] ACENDE  = 3'd2;
   localparam logic [2:0] APAGA   = 3'd3;
   localparam logic [2:0] PROXIMO = 3'd4;
   localparam logic [2:0] FIM     = 3'd5;

   logic [2:0]    estado_q,   estado_d;
   logic [3:0]    endereco_q, endereco_d;
   logic [3:0]    limite_q,   limite_d;
   logic [TW-1:0] timer_q,    timer_d;

   always_comb begin
      estado_d   = estado_q;
      endereco_d = endereco_q;
      limite_d   = limite_q;
      timer_d    = timer_q;
      case (estado_q)
         INICIAL: begin
            if (bus.iniciar && !bus.abortar) begin
               estado_d = PREPARA;
               limite_d = bus.limite;
            end
         end
         PREPARA: begin
            endereco_d = 4'd0;
            timer_d    = '0;
            estado_d   = ACENDE;
         end
         ACENDE: begin
            if (timer_q == FIM_ACESO) begin
               timer_d  = '0;
               estado_d = APAGA;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         APAGA: begin
            if (timer_q == FIM_APAGADO) begin
               timer_d  = '0;
               estado_d = (endereco_q == limite_q) ? FIM : PROXIMO;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         PROXIMO: begin
            endereco_d = endereco_q + 4'd1;
            estado_d   = ACENDE;
         end
         FIM:     estado_d = INICIAL;
         default: estado_d = INICIAL;
      endcase

      // Abort overrides every transition, including a pending pronto.
      if (bus.abortar && (estado_q != INICIAL)) begin
         estado_d   = INICIAL;
         timer_d    = '0;
         endereco_d = 4'd0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q   <= INICIAL;
         endereco_q <= 4'd0;
         limite_q   <= 4'd0;
         timer_q    <= '0;
      end else begin
         estado_q   <= estado_d;
         endereco_q <= endereco_d;
         limite_q   <= limite_d;
         timer_q    <= timer_d;
      end
   end

   assign bus.endereco  = endereco_q;
   assign bus.leds      = (estado_q == ACENDE) ? bus.dado_memoria : 4'b0000;
   assign bus.ocupado   = (estado_q != INICIAL);
   assign bus.pronto    = (estado_q == FIM);
   assign bus.db_estado = {1'b0, estado_q};

`ifdef EXIBE_SEQUENCIA_RGB_EN
   always_comb begin
      case (bus.leds)
         4'b0001: bus.rgb = 3'b100;
         4'b0010: bus.rgb = 3'b010;
         4'b0100: bus.rgb = 3'b001;
         4'b1000: bus.rgb = 3'b110;
         default: bus.rgb = 3'b000;
      endcase
   end
`endif
endmodule

// File: tb/tb_exibe_sequencia_ctrl.sv
// Directed bench for the sequence playback controller with short show/gap times.
module tb_exibe_sequencia_ctrl;
   localparam int TA = 4;
   localparam int TP = 2;
   localparam int PER = TA + TP + 1;

   logic clk;
   logic rst_n;
   logic [3:0] mem [16];
   int n_cmp;
   int n_err;

   exibe_sequencia_ctrl_if bus ();

   exibe_sequencia_ctrl #(.T_ACESO(TA), .T_APAGADO(TP)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   assign bus.dado_memoria = mem[bus.endereco];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Plays one sequence and checks every cycle against the cycle-position model:
   // cycle 1 PREPARA, then per code TA cycles ACENDE, TP cycles APAGA, one PROXIMO.
   task automatic run_playback(input logic [3:0] lim, input bit poke);
      int l;
      int n;
      int off, idx, pos;
      logic [3:0] e_leds, e_est, e_end;
      logic e_pronto;
      l = int'(lim);
      n = 1 + (l + 1) * (TA + TP) + l + 1;
      bus.limite  = lim;
      bus.iniciar = 1'b1;
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         if (c == 1) bus.iniciar = 1'b0;
         if (poke && c == 3) begin
            bus.iniciar = 1'b1;
            bus.limite  = 4'd7;
         end
         if (poke && c == 5) bus.iniciar = 1'b0;
         off = c - 2;
         idx = (c >= 2) ? off / PER : 0;
         pos = (c >= 2) ? off % PER : 0;
         e_leds = 4'b0000;
         e_pronto = 1'b0;
         e_end = 4'(idx);
         if (c == n) begin
            e_est = 4'd5;
            e_pronto = 1'b1;
            e_end = lim;
         end else if (c == 1) begin
            e_est = 4'd1;
         end else if (pos < TA) begin
            e_est = 4'd2;
            e_leds = mem[idx];
         end else if (pos < TA + TP) begin
            e_est = 4'd3;
         end else begin
            e_est = 4'd4;
         end
         n_cmp++;
         if (bus.leds !== e_leds) begin
            n_err++;
            $display("FAIL leds lim=%0d cycle=%0d got=%b want=%b", l, c, bus.leds, e_leds);
         end
         n_cmp++;
         if (bus.pronto !== e_pronto) begin
            n_err++;
            $display("FAIL pronto lim=%0d cycle=%0d got=%b want=%b", l, c, bus.pronto, e_pronto);
         end
         n_cmp++;
         if (bus.ocupado !== 1'b1) begin
            n_err++;
            $display("FAIL ocupado lim=%0d cycle=%0d got=%b want=1", l, c, bus.ocupado);
         end
         n_cmp++;
         if (bus.db_estado !== e_est) begin
            n_err++;
            $display("FAIL db_estado lim=%0d cycle=%0d got=%0d want=%0d", l, c, bus.db_estado, e_est);
         end
         if (c >= 2) begin
            n_cmp++;
            if (bus.endereco !== e_end) begin
               n_err++;
               $display("FAIL endereco lim=%0d cycle=%0d got=%0d want=%0d", l, c, bus.endereco, e_end);
            end
         end
      end
      @(negedge clk);
      n_cmp++;
      if (bus.db_estado !== 4'd0 || bus.ocupado !== 1'b0 || bus.pronto !== 1'b0) begin
         n_err++;
         $display("FAIL after_fim lim=%0d got est=%0d ocup=%b pronto=%b want 0/0/0",
                  l, bus.db_estado, bus.ocupado, bus.pronto);
      end
   endtask

   task automatic test_reset;
      n_cmp++;
      if (bus.leds !== 4'b0000 || bus.ocupado !== 1'b0 || bus.pronto !== 1'b0 ||
          bus.db_estado !== 4'd0 || bus.endereco !== 4'd0) begin
         n_err++;
         $display("FAIL reset_state got leds=%b ocup=%b pronto=%b est=%0d end=%0d want 0",
                  bus.leds, bus.ocupado, bus.pronto, bus.db_estado, bus.endereco);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.db_estado !== 4'd0) begin
         n_err++;
         $display("FAIL idle_after_reset got=%0d want=0", bus.db_estado);
      end
   endtask

   task automatic test_full_playback;
      mem[0] = 4'b0001;
      mem[1] = 4'b0010;
      mem[2] = 4'b0100;
      run_playback(4'd2, 1'b0);
   endtask

   task automatic test_limite_zero;
      mem[0] = 4'b1000;
      run_playback(4'd0, 1'b0);
   endtask

   task automatic test_ignore_iniciar;
      mem[0] = 4'b0010;
      run_playback(4'd0, 1'b1);
   endtask

   task automatic test_limite_max;
      for (int i = 0; i < 16; i++) mem[i] = 4'((i * 5 + 3) % 16);
      run_playback(4'd15, 1'b0);
   endtask

   task automatic test_back_to_back;
      mem[0] = 4'b0100;
      mem[1] = 4'b1001;
      run_playback(4'd1, 1'b0);
      run_playback(4'd1, 1'b0);
   endtask

   task automatic test_abort;
      bus.limite  = 4'd2;
      bus.iniciar = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) bus.iniciar = 1'b0;
      end
      bus.abortar = 1'b1;
      @(negedge clk);
      bus.abortar = 1'b0;
      n_cmp++;
      if (bus.db_estado !== 4'd0 || bus.leds !== 4'b0000 || bus.ocupado !== 1'b0 ||
          bus.endereco !== 4'd0) begin
         n_err++;
         $display("FAIL abort got est=%0d leds=%b ocup=%b end=%0d want 0/0000/0/0",
                  bus.db_estado, bus.leds, bus.ocupado, bus.endereco);
      end
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.pronto !== 1'b0 || bus.db_estado !== 4'd0) begin
            n_err++;
            $display("FAIL abort_no_pronto c=%0d got pronto=%b est=%0d want 0/0",
                     c, bus.pronto, bus.db_estado);
         end
      end
   endtask

   task automatic test_start_with_abort;
      bus.limite  = 4'd1;
      bus.iniciar = 1'b1;
      bus.abortar = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.db_estado !== 4'd0 || bus.ocupado !== 1'b0) begin
            n_err++;
            $display("FAIL start_abort c=%0d got est=%0d ocup=%b want 0/0",
                     c, bus.db_estado, bus.ocupado);
         end
      end
      bus.iniciar = 1'b0;
      bus.abortar = 1'b0;
   endtask

   task automatic test_reset_mid;
      mem[0] = 4'b0001;
      bus.limite  = 4'd3;
      bus.iniciar = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         if (c == 1) bus.iniciar = 1'b0;
      end
      n_cmp++;
      if (bus.leds !== 4'b0001) begin
         n_err++;
         $display("FAIL pre_reset_leds got=%b want=0001", bus.leds);
      end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.leds !== 4'b0000 || bus.ocupado !== 1'b0 || bus.db_estado !== 4'd0 ||
          bus.pronto !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid got leds=%b ocup=%b est=%0d pronto=%b want 0000/0/0/0",
                  bus.leds, bus.ocupado, bus.db_estado, bus.pronto);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.endereco !== 4'd0 || bus.db_estado !== 4'd0) begin
         n_err++;
         $display("FAIL after_reset_release got end=%0d est=%0d want 0/0",
                  bus.endereco, bus.db_estado);
      end
   endtask

`ifdef EXIBE_SEQUENCIA_RGB_EN
   task automatic test_rgb;
      logic [3:0] pat [3];
      logic [2:0] want [3];
      pat[0] = 4'b1000; want[0] = 3'b110;
      pat[1] = 4'b0011; want[1] = 3'b000;
      pat[2] = 4'b0001; want[2] = 3'b100;
      for (int k = 0; k < 3; k++) begin
         mem[0] = pat[k];
         bus.limite  = 4'd0;
         bus.iniciar = 1'b1;
         for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
               bus.iniciar = 1'b0;
               n_cmp++;
               if (bus.rgb !== 3'b000) begin
                  n_err++;
                  $display("FAIL rgb_blank got=%b want=000", bus.rgb);
               end
            end
         end
         n_cmp++;
         if (bus.rgb !== want[k]) begin
            n_err++;
            $display("FAIL rgb leds=%b got=%b want=%b", pat[k], bus.rgb, want[k]);
         end
         bus.abortar = 1'b1;
         @(negedge clk);
         bus.abortar = 1'b0;
      end
   endtask
`endif

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.iniciar = 1'b0;
      bus.abortar = 1'b0;
      bus.limite  = 4'd0;
      for (int i = 0; i < 16; i++) mem[i] = 4'd0;
      #12;
      test_reset();
      test_full_playback();
      test_limite_zero();
      test_ignore_iniciar();
      test_limite_max();
      test_back_to_back();
      test_abort();
      test_start_with_abort();
      test_reset_mid();
`ifdef EXIBE_SEQUENCIA_RGB_EN
      test_rgb();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/exibe_sequencia_ctrl.md
Name: exibe_sequencia_ctrl

Overview:
- Controller that plays back the stored colour sequence to the player before each round of the sequence-memory game.
- Sequences the sequence memory address from 0 up to the current round limit.
- Lights each stored code on the LEDs for a fixed time, then blanks them for a fixed gap.
- Sits between the game control unit, which starts it and waits on `pronto`, and the datapath memory/LED outputs. The control unit does not run its own address counter during playback.

Parameters:
- T_ACESO, 1000, clock cycles each code is shown on the LEDs (must be >= 1).
- T_APAGADO, 500, clock cycles of blank gap after each code (must be >= 1).

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- iniciar  input  1  start request; sampled only in INICIAL.
- abortar  input  1  synchronous abort; returns the block to INICIAL.
- limite  input  4  index of the last sequence entry to show; latched at start.
- dado_memoria  input  4  code read from the sequence memory at `endereco` (asynchronous read, same cycle).
- endereco  output  4  registered memory address.
- leds  output  4  `dado_memoria` while in ACENDE, otherwise 0000 (combinational from state).
- ocupado  output  1  1 in every state except INICIAL.
- pronto  output  1  one-cycle pulse in FIM.
- db_estado  output  4  state code for the hexa7seg debug display.

Behaviour:
- **Reset** (reset=0, asynchronous): state INICIAL; endereco=0; limite_reg=0; timer=0.
  - Outputs during reset: leds=0000, ocupado=0, pronto=0, db_estado=0.
- **Timer:** width clog2(max(T_ACESO, T_APAGADO)) bits.
- **State codes (db_estado):** INICIAL=0, PREPARA=1, ACENDE=2, APAGA=3, PROXIMO=4, FIM=5.
- **State transitions:**
  - INICIAL: if iniciar=1 and abortar=0 -> PREPARA, limite_reg<=limite. Otherwise stay.
  - PREPARA: endereco<=0, timer<=0 -> ACENDE. Lasts one cycle.
  - ACENDE: leds=dado_memoria; timer increments each cycle. When timer==T_ACESO-1: timer<=0 -> APAGA.
  - APAGA: leds=0; timer increments. When timer==T_APAGADO-1: timer<=0; then -> FIM if endereco==limite_reg, else -> PROXIMO.
  - PROXIMO: endereco<=endereco+1 -> ACENDE. Lasts one cycle.
  - FIM: pronto=1 -> INICIAL. Lasts one cycle; endereco holds its value.
- **abortar=1** in any state other than INICIAL: next state INICIAL, timer<=0, endereco<=0, no pronto pulse.
  - abortar has priority over every other transition, including iniciar in INICIAL.
- **iniciar** is ignored while ocupado=1. `limite` changes after start have no effect.
- **Total playback length** from the iniciar sampling edge to the pronto cycle: 1 + (L+1)*(T_ACESO+T_APAGADO) + L + 1 cycles, where L=limite_reg.
- **Boundaries:**
  - limite=0: exactly one code is shown.
  - limite=15: 16 codes are shown; endereco reaches 15 and never wraps.
- **Reset asserted mid-playback:** immediate return to the reset values above, independent of the clock.

Optional Feature:
- Macro: EXIBE_SEQUENCIA_RGB_EN.
- **Defined:** adds output `rgb[2:0]`, derived combinationally from `leds`:
  - 0001 -> 100 (red), 0010 -> 010 (green), 0100 -> 001 (blue), 1000 -> 110 (yellow).
  - Any other value, including 0000 -> 000.
- **Undefined:** no `rgb` port and no related logic; all other behaviour is identical.

Test Plan:
- **Reset:** reset=0 mid-ACENDE -> same cycle: leds=0000, ocupado=0, db_estado=0; after release, endereco=0.
- **Full playback:** T_ACESO=4, T_APAGADO=2, limite=2, memory {0001, 0010, 0100}, iniciar pulsed.
  - Required: leds=0001 in cycles 2-5, 0010 in cycles 9-12, 0100 in cycles 16-19, 0000 in all other cycles.
  - pronto=1 only in cycle 22; ocupado=1 in cycles 1-22.
- **limite=0:** one code shown for 4 cycles; pronto in cycle 8; endereco never leaves 0.
- **limite=15:** 16 codes shown; endereco steps 0..15 without wrap; pronto in cycle 113.
- **Abort:** abortar=1 in cycle 10 of a playback -> db_estado=0 and leds=0 in cycle 11, no pronto.
  - iniciar toggled while ocupado=1 is ignored.
  - iniciar=1 together with abortar=1 in INICIAL -> stays in INICIAL.
- **RGB (macro defined):** leds 1000 -> rgb=110; leds 0000 -> rgb=000; leds 0011 -> rgb=000.
